// File: rtl/uart_tx_arb_if.sv
// Requester-side handshake bundle for uart_tx_arb: two request/data pairs,
// their accept pulses and the index of the requester owning the line.
interface uart_tx_arb_if;
    logic       req0;
    logic       req1;
    logic [7:0] data0;
    logic [7:0] data1;
    logic       ack0;
    logic       ack1;
    logic       grant;

    modport master (
        output req0, req1, data0, data1,
        input  ack0, ack1, grant
    );

    modport slave (
        input  req0, req1, data0, data1,
        output ack0, ack1, grant
    );
endinterface

// File: rtl/uart_tx_arb.sv
// Two-requester round-robin UART transmitter: start, 8 data bits MSB first,
// optional even parity (macro UART_TX_PARITY_EN), STOP_BITS stop bits.
module uart_tx_arb #(
    parameter int DIV       = 16,
    parameter int STOP_BITS = 1
) (
    input  logic         clk_sample,
    input  logic         rst,
    uart_tx_arb_if.slave bus,
    output logic         serial_out,
    output logic         busy
);

    localparam int CW = $clog2(DIV);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   baud_reg, baud_next;
    logic [2:0]      bit_reg, bit_next;
    logic [7:0]      shift_reg, shift_next;
    logic            grant_reg, grant_next;
    logic            rr_reg, rr_next;
    logic            ack0_reg, ack0_next;
    logic            ack1_reg, ack1_next;
    logic            busy_reg, busy_next;
    logic            serial_reg, serial_next;
`ifdef UART_TX_PARITY_EN
    logic            parity_reg, parity_next;
`endif

    logic            baud_last;
    logic            pick;
    logic [7:0]      pick_data;

    always_ff @(posedge clk_sample or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            baud_reg   <= '0;
            bit_reg    <= '0;
            shift_reg  <= '0;
            grant_reg  <= 1'b0;
            rr_reg     <= 1'b0;
            ack0_reg   <= 1'b0;
            ack1_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            serial_reg <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            baud_reg   <= baud_next;
            bit_reg    <= bit_next;
            shift_reg  <= shift_next;
            grant_reg  <= grant_next;
            rr_reg     <= rr_next;
            ack0_reg   <= ack0_next;
            ack1_reg   <= ack1_next;
            busy_reg   <= busy_next;
            serial_reg <= serial_next;
`ifdef UART_TX_PARITY_EN
            parity_reg <= parity_next;
`endif
        end
    end

    always_comb begin
        state_next  = state_reg;
        baud_next   = baud_reg;
        bit_next    = bit_reg;
        shift_next  = shift_reg;
        grant_next  = grant_reg;
        rr_next     = rr_reg;
        ack0_next   = 1'b0;
        ack1_next   = 1'b0;
        busy_next   = busy_reg;
        serial_next = serial_reg;
`ifdef UART_TX_PARITY_EN
        parity_next = parity_reg;
`endif
        baud_last = (baud_reg == CW'(DIV - 1));
        // rr_reg names the requester that wins a tie; it flips away from each winner
        pick      = (bus.req0 && bus.req1) ? rr_reg : bus.req1;
        pick_data = pick ? bus.data1 : bus.data0;

        if (state_reg != IDLE) begin
            baud_next = baud_last ? '0 : baud_reg + CW'(1);
        end

        case (state_reg)
            IDLE: begin
                baud_next   = '0;
                busy_next   = 1'b0;
                serial_next = 1'b1;
                if (bus.req0 || bus.req1) begin
                    state_next  = START;
                    shift_next  = pick_data;
                    grant_next  = pick;
                    rr_next     = ~pick;
                    ack0_next   = ~pick;
                    ack1_next   = pick;
                    busy_next   = 1'b1;
                    serial_next = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_next = ^pick_data;
`endif
                end
            end
            START: begin
                if (baud_last) begin
                    state_next  = DATA;
                    bit_next    = '0;
                    serial_next = shift_reg[7];
                end
            end
            DATA: begin
                if (baud_last) begin
                    if (bit_reg == 3'd7) begin
                        bit_next = '0;
`ifdef UART_TX_PARITY_EN
                        state_next  = PARITY;
                        serial_next = parity_reg;
`else
                        state_next  = STOP;
                        serial_next = 1'b1;
`endif
                    end else begin
                        bit_next    = bit_reg + 3'd1;
                        shift_next  = {shift_reg[6:0], 1'b0};
                        serial_next = shift_reg[6];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_last) begin
                    state_next  = STOP;
                    bit_next    = '0;
                    serial_next = 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_last) begin
                    if (bit_reg == 3'(STOP_BITS - 1)) begin
                        state_next  = IDLE;
                        busy_next   = 1'b0;
                        serial_next = 1'b1;
                    end else begin
                        bit_next = bit_reg + 3'd1;
                    end
                end
            end
            default: begin
                state_next  = IDLE;
                busy_next   = 1'b0;
                serial_next = 1'b1;
            end
        endcase
    end

    assign bus.ack0   = ack0_reg;
    assign bus.ack1   = ack1_reg;
    assign bus.grant  = grant_reg;
    assign serial_out = serial_reg;
    assign busy       = busy_reg;

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter DIV, default 16, meaning clk_sample cycles per serial bit (>=2).
REQ-002 SHALL have parameter STOP_BITS, default 1, meaning number of stop bits per frame (1 or 2).
REQ-003 SHALL have port clk_sample  input  1  single clock, rising-edge active.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports req0, req1  input  1 each  requester wants to send a byte.
REQ-006 SHALL have ports data0, data1  input  8 each  byte offered by the matching requester.
REQ-007 SHALL have ports ack0, ack1  output  1 each  one-cycle pulse: byte accepted.
REQ-008 SHALL have port serial_out  output  1  UART line, idle high.
REQ-009 SHALL have port busy  output  1  high while a frame is on the line.
REQ-010 SHALL have port grant  output  1  index of the requester owning the current or last frame.

Function
REQ-011 SHALL implement states IDLE, START, DATA, PARITY, STOP; one bit period equals DIV clk_sample cycles, timed by a baud counter that restarts at each state entry.
REQ-012 SHALL, in IDLE with any req high at a rising edge, at that edge: select a requester, latch its data, pulse its ack for one cycle, set grant, enter START, drive serial_out low, and set busy high.
REQ-013 SHALL arbitrate round-robin: with one request, grant it; with both, grant the requester not granted last; after reset, req0 wins a tie.
REQ-014 SHALL require the requester to hold req and data stable until ack; a req dropped before ack SHALL be ignored with no ack.
REQ-015 SHALL send frame order: start bit 0, 8 data bits MSB first, even parity bit (XOR of the 8 bits), then STOP_BITS stop bits of 1.
REQ-016 SHALL hold each bit on serial_out for exactly DIV cycles, so a frame lasts (11+STOP_BITS-1)*DIV cycles with parity.
REQ-017 SHALL NOT change the latched byte or grant during a frame, regardless of req/data activity.
REQ-018 SHALL, at the end of the last stop bit, return to IDLE; when a req is already high, the next start bit SHALL begin on the following edge (one-cycle IDLE gap, back-to-back frames).
REQ-019 SHALL drop busy in the IDLE cycle and SHALL never assert ack0 and ack1 in the same cycle.
REQ-020 SHALL keep requests arriving mid-frame pending, without ack, until IDLE.

Reset
REQ-021 SHALL, with rst low, asynchronously force: state IDLE, serial_out 1, busy 0, ack0 0, ack1 0, grant 0, baud counter 0, round-robin pointer favouring req0.
REQ-022 SHALL abort any frame in progress on reset with no further bits; the aborted byte is lost and SHALL not be re-acked.
REQ-023 SHALL resume arbitration on the first rising edge after rst returns high.

Configuration
REQ-024 SHALL, with macro UART_TX_PARITY_EN defined, include the PARITY state and send the even parity bit.
REQ-025 SHALL, without UART_TX_PARITY_EN, omit the PARITY state: STOP follows the 8th data bit, and frame length is (10+STOP_BITS-1)*DIV cycles.

Verification
REQ-026 SHALL cover: UART_TX_PARITY_EN defined, DIV=16; req0 with data0=8'b10011001 -> ack0 pulse, line 0_10011001_0_1 with 16 cycles per bit, busy high for 176 cycles.
REQ-027 SHALL cover: req1 with data1=8'b11000010 -> ack1, line 0_11000010_1_1 (parity 1).
REQ-028 SHALL cover: req0 and req1 high together and held -> frames to grant 0, then 1, then 0, each separated by one idle cycle, acks alternating.
REQ-029 SHALL cover: rst low 40 cycles into a frame -> serial_out 1 and busy 0 immediately, no ack until a new req after release.
REQ-030 SHALL cover: UART_TX_PARITY_EN undefined, STOP_BITS=2, data0=8'h5A -> line 0_01011010_1_1, 176 cycles total.
REQ-031 SHALL cover: req1 pulsed high then low mid-frame -> no ack1, no frame for requester 1.
